// File: rtl/muldiv_ctrl_if.sv
// Handshake and result bus between the EX stage and the mul/div sequencer.
// master = EX-stage side (drives operands), slave = sequencer side.
interface muldiv_ctrl_if;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic        cancel_i;
  logic        hi_we_i;
  logic        lo_we_i;
  logic [31:0] hilo_wdata_i;
  logic        stallreq_o;
  logic        busy_o;
  logic        done_o;
  logic        div_by_zero_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output start_i, op_i, src1_i, src2_i, cancel_i, hi_we_i, lo_we_i, hilo_wdata_i,
    input  stallreq_o, busy_o, done_o, div_by_zero_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, src1_i, src2_i, cancel_i, hi_we_i, lo_we_i, hilo_wdata_i,
    output stallreq_o, busy_o, done_o, div_by_zero_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// MIPS MULT/MULTU/DIV/DIVU sequencer owning HI/LO: iterative shift-add multiply, restoring divide.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiply in the MUL state; divide stays iterative.
module muldiv_ctrl #(
  parameter int ITER = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.slave  bus
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [63:0]   r_acc;
  logic [31:0]   r_opnd;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic          r_negQ;
  logic          r_negR;
  logic          r_isDiv;
  logic          r_dz;

  logic          w_stall;
  logic          w_done;
  logic          w_dzOut;
  logic          w_go;
  logic          w_s1;
  logic          w_s2;
  logic [31:0]   w_mag1;
  logic [31:0]   w_mag2;
  logic          w_divZero;
  logic          w_lastIter;
  logic [32:0]   w_shift;
  logic          w_ge;
  logic [31:0]   w_sub;
  logic [63:0]   w_divNext;
  logic [63:0]   w_mulNext;
  logic [63:0]   w_prodFinal;
  logic [31:0]   w_quoFinal;
  logic [31:0]   w_remFinal;

  // Signed ops run on magnitudes; the sign is re-applied once in DONE.
  assign w_go      = bus.start_i & ~bus.cancel_i;
  assign w_s1      = ~bus.op_i[0] & bus.src1_i[31];
  assign w_s2      = ~bus.op_i[0] & bus.src2_i[31];
  assign w_mag1    = w_s1 ? (32'd0 - bus.src1_i) : bus.src1_i;
  assign w_mag2    = w_s2 ? (32'd0 - bus.src2_i) : bus.src2_i;
  assign w_divZero = bus.op_i[1] & (bus.src2_i == 32'd0);
  assign w_lastIter = (r_cnt == CW'(ITER - 1));

  // Divide: r_acc = {remainder, dividend/quotient}; quotient bits shift in from the right.
  assign w_shift   = {r_acc[63:32], r_acc[31]};
  assign w_ge      = (w_shift >= {1'b0, r_opnd});
  assign w_sub     = w_shift[31:0] - r_opnd;
  assign w_divNext = w_ge ? {w_sub, r_acc[30:0], 1'b1}
                          : {w_shift[31:0], r_acc[30:0], 1'b0};

`ifdef MULDIV_FAST_MUL_EN
  assign w_mulNext = 64'(r_opnd) * 64'(r_acc[31:0]);
`else
  logic [32:0] w_addHi;
  // Multiply: r_acc = {partial product, multiplier}; shifts right one bit per cycle.
  assign w_addHi   = r_acc[0] ? ({1'b0, r_acc[63:32]} + {1'b0, r_opnd})
                              : {1'b0, r_acc[63:32]};
  assign w_mulNext = {w_addHi, r_acc[31:1]};
`endif

  assign w_prodFinal = r_negQ ? (64'd0 - r_acc) : r_acc;
  assign w_quoFinal  = r_negQ ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
  assign w_remFinal  = r_negR ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_done  = 1'b0;
    w_dzOut = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = w_go;
        if (w_go) begin
          if (w_divZero)          w_next = DONE;
          else if (bus.op_i[1])   w_next = DIV;
          else                    w_next = MUL;
        end
      end
      MUL: begin
        w_stall = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
        w_next = bus.cancel_i ? IDLE : DONE;
`else
        if (bus.cancel_i)    w_next = IDLE;
        else if (w_lastIter) w_next = DONE;
`endif
      end
      DIV: begin
        w_stall = 1'b1;
        if (bus.cancel_i)    w_next = IDLE;
        else if (w_lastIter) w_next = DONE;
      end
      DONE: begin
        w_done  = ~bus.cancel_i;
        w_dzOut = r_dz & ~bus.cancel_i;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_negQ  <= 1'b0;
      r_negR  <= 1'b0;
      r_isDiv <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!bus.cancel_i) begin
            if (bus.hi_we_i) r_hi <= bus.hilo_wdata_i;
            if (bus.lo_we_i) r_lo <= bus.hilo_wdata_i;
            if (bus.start_i) begin
              r_cnt   <= '0;
              r_acc   <= {32'd0, bus.op_i[1] ? w_mag1 : w_mag2};
              r_opnd  <= bus.op_i[1] ? w_mag2 : w_mag1;
              r_negQ  <= w_s1 ^ w_s2;
              r_negR  <= w_s1;
              r_isDiv <= bus.op_i[1];
              r_dz    <= w_divZero;
            end
          end
        end
        MUL: begin
          r_acc <= w_mulNext;
          r_cnt <= r_cnt + CW'(1);
        end
        DIV: begin
          r_acc <= w_divNext;
          r_cnt <= r_cnt + CW'(1);
        end
        DONE: begin
          // A cancelled or divide-by-zero DONE leaves HI/LO untouched.
          if (!bus.cancel_i && !r_dz) begin
            if (r_isDiv) begin
              r_hi <= w_remFinal;
              r_lo <= w_quoFinal;
            end else begin
              r_hi <= w_prodFinal[63:32];
              r_lo <= w_prodFinal[31:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stallreq_o    = w_stall;
  assign bus.busy_o        = (r_state != IDLE);
  assign bus.done_o        = w_done;
  assign bus.div_by_zero_o = w_dzOut;
  assign bus.hi_o          = r_hi;
  assign bus.lo_o          = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected HI/LO come from native SV arithmetic,
// pushed when an op is issued and popped when done_o pulses.
module tb_muldiv_ctrl;

  logic clk;
  logic rst;

  muldiv_ctrl_if bus ();

  muldiv_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sbQ[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  // Reference behaviour: updates the HI/LO model and returns what the DUT should commit.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output exp_t e);
    int sa;
    int sb;
    longint ps;
    logic [63:0] pu;
    sa = a;
    sb = b;
    e.dz = 1'b0;
    case (op)
      2'b00: begin
        ps = longint'(sa) * longint'(sb);
        pu = ps;
        mHi = pu[63:32];
        mLo = pu[31:0];
      end
      2'b01: begin
        pu = 64'(a) * 64'(b);
        mHi = pu[63:32];
        mLo = pu[31:0];
      end
      2'b10: begin
        if (b == 32'd0) e.dz = 1'b1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          mLo = 32'h8000_0000;
          mHi = 32'd0;
        end else begin
          mLo = sa / sb;
          mHi = sa % sb;
        end
      end
      default: begin
        if (b == 32'd0) e.dz = 1'b1;
        else begin
          mLo = a / b;
          mHi = a % b;
        end
      end
    endcase
    e.hi = mHi;
    e.lo = mLo;
  endtask

  // Presents one instruction for cycle N; returns at N+1, one step after the edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.src1_i  = a;
    bus.src2_i  = b;
    @(negedge clk);
    checkOutput("stall_start", 64'(bus.stallreq_o), 64'd1);
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    exp_t got;
    int expLat;
    int lat;
    int stallCnt;
    bit seen;
    model(op, a, b, e);
    sbQ.push_back(e);
    expLat = (op[1] && b == 32'd0) ? 1 : (op[1] ? 33 : MUL_LAT);
    applyStimulus(op, a, b);
    stallCnt = 0;
    seen = 1'b0;
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (bus.done_o) begin
        lat = i;
        seen = 1'b1;
        break;
      end
      if (bus.stallreq_o) stallCnt++;
    end
    if (!seen) begin
      checkOutput("done_timeout", 64'd0, 64'd1);
      sbQ.pop_front();
      @(posedge clk);
      #1;
      return;
    end
    checkOutput("latency", 64'(lat), 64'(expLat));
    checkOutput("stall_cycles", 64'(stallCnt), 64'(expLat - 1));
    checkOutput("stall_in_done", 64'(bus.stallreq_o), 64'd0);
    got = sbQ.pop_front();
    checkOutput("div_by_zero", 64'(bus.div_by_zero_o), 64'(got.dz));
    @(posedge clk);
    #1;
    checkOutput("hi", 64'(bus.hi_o), 64'(got.hi));
    checkOutput("lo", 64'(bus.lo_o), 64'(got.lo));
    checkOutput("busy_after", 64'(bus.busy_o), 64'd0);
  endtask

  task automatic mtWrite(input logic hiWe, input logic loWe, input logic [31:0] d);
    bus.hi_we_i = hiWe;
    bus.lo_we_i = loWe;
    bus.hilo_wdata_i = d;
    @(posedge clk);
    #1;
    bus.hi_we_i = 1'b0;
    bus.lo_we_i = 1'b0;
    if (hiWe) mHi = d;
    if (loWe) mLo = d;
  endtask

  initial begin
    int doneCnt;
    logic [1:0] rop;
    logic [31:0] ra;
    logic [31:0] rb;

    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.op_i = 2'b00;
    bus.src1_i = 32'd0;
    bus.src2_i = 32'd0;
    bus.cancel_i = 1'b0;
    bus.hi_we_i = 1'b0;
    bus.lo_we_i = 1'b0;
    bus.hilo_wdata_i = 32'd0;
    #3;
    checkOutput("rst_hi", 64'(bus.hi_o), 64'd0);
    checkOutput("rst_lo", 64'(bus.lo_o), 64'd0);
    checkOutput("rst_busy", 64'(bus.busy_o), 64'd0);
    checkOutput("rst_stall", 64'(bus.stallreq_o), 64'd0);
    checkOutput("rst_done", 64'(bus.done_o), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    runOp(2'b00, 32'hFFFF_FFFD, 32'd5);
    runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runOp(2'b10, 32'hFFFF_FFF9, 32'd2);
    runOp(2'b11, 32'd7, 32'd2);
    runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);

    mtWrite(1'b1, 1'b0, 32'h11);
    mtWrite(1'b0, 1'b1, 32'h22);
    checkOutput("mthi", 64'(bus.hi_o), 64'h11);
    checkOutput("mtlo", 64'(bus.lo_o), 64'h22);
    runOp(2'b11, 32'd1234, 32'd0);

    // Cancel landing on a divide-by-zero DONE cycle: no pulse, no write.
    applyStimulus(2'b11, 32'd99, 32'd0);
    bus.cancel_i = 1'b1;
    @(negedge clk);
    checkOutput("cancel_done_pulse", 64'(bus.done_o), 64'd0);
    checkOutput("cancel_dz_pulse", 64'(bus.div_by_zero_o), 64'd0);
    @(posedge clk);
    #1;
    bus.cancel_i = 1'b0;
    checkOutput("cancel_done_busy", 64'(bus.busy_o), 64'd0);
    checkOutput("cancel_done_hi", 64'(bus.hi_o), 64'(mHi));

    // Cancel mid-divide at N+10, with an MTLO attempted while busy.
    applyStimulus(2'b10, 32'd1000, 32'd7);
    bus.lo_we_i = 1'b1;
    bus.hilo_wdata_i = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.lo_we_i = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    bus.cancel_i = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel_i = 1'b0;
    checkOutput("cancel_busy", 64'(bus.busy_o), 64'd0);
    checkOutput("cancel_stall", 64'(bus.stallreq_o), 64'd0);
    doneCnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o) doneCnt++;
    end
    checkOutput("cancel_no_done", 64'(doneCnt), 64'd0);
    checkOutput("cancel_hi", 64'(bus.hi_o), 64'(mHi));
    checkOutput("cancel_lo", 64'(bus.lo_o), 64'(mLo));
    @(posedge clk);
    #1;

    // Cancel wins over a simultaneous start.
    bus.start_i = 1'b1;
    bus.cancel_i = 1'b1;
    bus.op_i = 2'b00;
    bus.src1_i = 32'd3;
    bus.src2_i = 32'd3;
    @(negedge clk);
    checkOutput("prio_stall", 64'(bus.stallreq_o), 64'd0);
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.cancel_i = 1'b0;
    checkOutput("prio_busy", 64'(bus.busy_o), 64'd0);

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) rb = rb >> 24;
      runOp(rop, ra, rb);
    end

    // Asynchronous reset in the middle of a multiply.
    applyStimulus(2'b00, 32'd123, 32'd456);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_busy", 64'(bus.busy_o), 64'd0);
    checkOutput("arst_hi", 64'(bus.hi_o), 64'd0);
    checkOutput("arst_lo", 64'(bus.lo_o), 64'd0);
    checkOutput("arst_stall", 64'(bus.stallreq_o), 64'd0);
    mHi = 32'd0;
    mLo = 32'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    runOp(2'b00, 32'd6, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer for MIPS MULT/MULTU/DIV/DIVU, instantiated beside the EX stage ALU.
- Runs a 32-iteration shift-add multiplier and a restoring divider, and owns the architectural HI/LO registers.
- Raises a stall request to the central stall controller so EX holds the instruction until the result is committed.

Parameters:
- ITER, 32, iterations per operation; counter width is clog2(ITER).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start_i  in  1  EX holds a mul/div instruction
- op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src1_i  in  32  rs value (multiplicand / dividend)
- src2_i  in  32  rt value (multiplier / divisor)
- cancel_i  in  1  abort the in-flight operation (exception flush)
- hi_we_i  in  1  MTHI write
- lo_we_i  in  1  MTLO write
- hilo_wdata_i  in  32  MTHI/MTLO data
- stallreq_o  out  1  request pipeline stall
- busy_o  out  1  FSM not IDLE
- done_o  out  1  one-cycle pulse; result committed this cycle
- div_by_zero_o  out  1  pulse with done_o for DIV/DIVU with src2_i==0
- hi_o  out  32  HI register (MFHI source)
- lo_o  out  32  LO register (MFLO source)

Behaviour:
- Reset (async): FSM=IDLE, counter=0, all working registers=0, hi_o=lo_o=0, stallreq_o/busy_o/done_o/div_by_zero_o=0. Reset in mid-operation discards the operation.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start_i=1 latches operands.
  - Signed ops latch magnitudes plus sign flags: quotient/product sign = s1^s2; remainder sign = s1.
  - Next state is MUL (op_i[1]=0) or DIV; counter cleared.
  - DIV with src2_i==0 goes directly to DONE with the dz flag set.
- MUL: one partial-product add and shift per cycle into a 64-bit accumulator. counter++; at counter==ITER-1 go DONE.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). counter++; at counter==ITER-1 go DONE.
- DONE:
  - Applies sign correction (two's-complement negate) and writes HI/LO at the clock edge ending this cycle.
  - MUL: HI=product[63:32], LO=product[31:0]. DIV: LO=quotient, HI=remainder.
  - done_o=1 this cycle; next state IDLE.
  - Divide-by-zero: HI/LO unchanged, div_by_zero_o=1.
- Latency: start_i seen in IDLE at cycle N; MUL/DIV occupy N+1..N+32; DONE at N+33; new HI/LO visible at N+34.
- Divide-by-zero latency: DONE at N+1.
- stallreq_o = (IDLE & start_i & ~cancel_i) | MUL | DIV. It is 0 in DONE, so the instruction leaves EX that cycle.
- busy_o = state!=IDLE.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No trap.
- cancel_i:
  - In any state: next state IDLE, HI/LO unchanged, no done_o.
  - Cancel during DONE suppresses the HI/LO write and the done_o pulse.
  - Cancel has priority over start_i.
- hi_we_i/lo_we_i:
  - Honoured only in IDLE and only when cancel_i=0; ignored otherwise.
  - If asserted together with start_i, the MT write takes effect at that edge and the operation later overwrites HI/LO.
- A start_i held high after done_o (the same instruction re-presented) never occurs: the EX register advances in the DONE cycle. No de-duplication logic is required.
- All outputs are registered except stallreq_o, busy_o, done_o and div_by_zero_o, which decode the state registers (stallreq_o also uses start_i/cancel_i).

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU compute the full 64-bit product with a single-cycle signed/unsigned 33x33 multiply in the MUL state. MUL lasts exactly one cycle, DONE at N+2, HI/LO visible at N+3. DIV is unchanged.
- Undefined: iterative multiply with the 33-cycle latency above.

Test Plan:
- MULT src1=0xFFFFFFFD (-3), src2=5 -> stallreq_o high N..N+32, done_o at N+33; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU x/0 with HI=0x11, LO=0x22 preloaded by MTHI/MTLO -> done_o and div_by_zero_o at N+1; HI/LO unchanged.
- DIV started, cancel_i at cycle N+10 -> IDLE at N+11, stallreq_o=0, no done_o, HI/LO unchanged. MTLO during busy is ignored.
- rst asserted asynchronously at N+5 of MULT -> outputs 0 immediately. After release, a new MULT 6x7 -> LO=42, HI=0.
